// File: rtl/izh_spike_monitor_if.sv
`default_nettype none
// ============================================================================
// Module   : izh_spike_monitor_if
// Purpose  : ISI valid/ready handshake bundle between the monitor and its consumer.
// Revision : 1.0 - initial release
// ============================================================================
interface izh_spike_monitor_if #(
  parameter int ISI_W = 12
) ();
  logic [ISI_W-1:0] isi_o;
  logic             isi_valid_o;
  logic             isi_ready_i;

  modport master (
    output isi_o,
    output isi_valid_o,
    input  isi_ready_i
  );

  modport slave (
    input  isi_o,
    input  isi_valid_o,
    output isi_ready_i
  );
endinterface
`default_nettype wire

// File: rtl/izh_spike_monitor.sv
`default_nettype none
// ============================================================================
// Module   : izh_spike_monitor
// Purpose  : Spike detector with hysteresis, ISI measurement and optional
//            windowed firing-rate counter (enabled by macro IZ_MON_RATE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module izh_spike_monitor #(
  parameter logic signed [7:0] V_PEAK  = 8'sd30,
  parameter logic signed [7:0] V_REARM = -8'sd40,
  parameter int                ISI_W   = 12,
  parameter int                WIN     = 1000,
  parameter int                RATE_W  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 step_i,
  input  logic [7:0]           v_i,
  output logic                 spike_o,
  izh_spike_monitor_if.master  isi,
  output logic                 overrun_o,
  output logic [RATE_W-1:0]    rate_o,
  output logic                 rate_valid_o
);

  localparam logic [0:0] ST_ARMED = 1'b0;
  localparam logic [0:0] ST_FIRED = 1'b1;

  logic              sample;
  logic signed [7:0] v_s;
  logic              at_peak;
  logic              below_rearm;
  logic [0:0]        state;
  logic [0:0]        state_nxt;
  logic              spike_det;
  logic [ISI_W-1:0]  isi_cnt;
  logic [ISI_W-1:0]  isi_cnt_inc;
  logic              have_prev;
  logic              isi_accept;
  logic              isi_load;

  assign sample      = ena & step_i;
  assign v_s         = $signed(v_i);
  assign at_peak     = (v_s >= V_PEAK);
  assign below_rearm = (v_s < V_REARM);

  // ---------------- detector FSM ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_ARMED;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (sample) begin
      case (state)
        ST_ARMED: if (at_peak)     state_nxt = ST_FIRED;
        ST_FIRED: if (below_rearm) state_nxt = ST_ARMED;
        default:                   state_nxt = ST_ARMED;
      endcase
    end
  end

  always_comb begin
    spike_det = 1'b0;
    if (sample && (state == ST_ARMED) && at_peak) begin
      spike_det = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      spike_o <= 1'b0;
    end else if (ena) begin
      spike_o <= spike_det;
    end
  end

  // ---------------- ISI counter ----------------
  // The incremented value doubles as the ISI: steps since the previous spike sample.
  assign isi_cnt_inc = (&isi_cnt) ? isi_cnt : isi_cnt + ISI_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_cnt   <= '0;
      have_prev <= 1'b0;
    end else if (sample) begin
      if (spike_det) begin
        isi_cnt   <= '0;
        have_prev <= 1'b1;
      end else begin
        isi_cnt   <= isi_cnt_inc;
      end
    end
  end

  // ---------------- ISI output register ----------------
  assign isi_accept = ena & isi.isi_valid_o & isi.isi_ready_i;
  assign isi_load   = spike_det & have_prev;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi.isi_o       <= '0;
      isi.isi_valid_o <= 1'b0;
      overrun_o       <= 1'b0;
    end else if (ena) begin
      if (isi_load) begin
        if (!isi.isi_valid_o || isi_accept) begin
          isi.isi_o       <= isi_cnt_inc;
          isi.isi_valid_o <= 1'b1;
        end else begin
          overrun_o       <= 1'b1;
        end
      end else if (isi_accept) begin
        isi.isi_valid_o <= 1'b0;
      end
    end
  end

  // ---------------- rate window ----------------
`ifdef IZ_MON_RATE_EN
  localparam int CNT_W = $clog2(WIN);

  logic [CNT_W-1:0]  win_cnt;
  logic [RATE_W-1:0] spk_cnt;
  logic [RATE_W-1:0] spk_cnt_inc;

  assign spk_cnt_inc = (&spk_cnt) ? spk_cnt : spk_cnt + RATE_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt      <= '0;
      spk_cnt      <= '0;
      rate_o       <= '0;
      rate_valid_o <= 1'b0;
    end else if (ena) begin
      rate_valid_o <= 1'b0;
      if (sample) begin
        if (win_cnt == CNT_W'(WIN - 1)) begin
          // A spike on the closing sample still belongs to this window.
          rate_o       <= spike_det ? spk_cnt_inc : spk_cnt;
          rate_valid_o <= 1'b1;
          win_cnt      <= '0;
          spk_cnt      <= '0;
        end else begin
          win_cnt <= win_cnt + CNT_W'(1);
          if (spike_det) begin
            spk_cnt <= spk_cnt_inc;
          end
        end
      end
    end
  end
`else
  assign rate_o       = '0;
  assign rate_valid_o = 1'b0;
`endif

endmodule
`default_nettype wire
